// File: rtl/vga_plot_sink_if.sv
// Pixel stream and framebuffer write port of the plot sink.
// The slave modport is the sink's view; master is the drawing-engine/framebuffer side.
interface vga_plot_sink_if;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;
    logic        in_ready;
    logic [14:0] fb_addr;
    logic [2:0]  fb_data;
    logic        fb_wr_en;
    logic        fb_ack;

    modport slave (
        input  vga_x, vga_y, vga_colour, vga_plot, fb_ack,
        output in_ready, fb_addr, fb_data, fb_wr_en
    );

    modport master (
        output vga_x, vga_y, vga_colour, vga_plot, fb_ack,
        input  in_ready, fb_addr, fb_data, fb_wr_en
    );
endinterface

// File: rtl/vga_plot_sink.sv
// Clips, queues and serialises plotted pixels into acknowledged framebuffer writes,
// with saturating statistics and a sticky overflow flag.
module vga_plot_sink #(
    parameter int DEPTH = 8,
    parameter int SCR_W = 160,
    parameter int SCR_H = 120
) (
    input  logic                 clk,
    input  logic                 rst_n,
    vga_plot_sink_if.slave       pix,
    input  logic                 clr_stats,
    output logic                 idle,
    output logic                 overflow,
    output logic [15:0]          pix_count,
    output logic [15:0]          clip_count,
    output logic [15:0]          drop_count
);

    localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_e;

    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic inc);
        if (inc && (v != 16'hFFFF)) begin
            return v + 16'd1;
        end else begin
            return v;
        end
    endfunction

    logic [17:0]   mem_q [DEPTH];
    logic [17:0]   head_s;
    logic          in_range_s;
    logic [14:0]   addr_s;
    logic          push_s;
    logic          drop_s;
    logic          clip_s;
    logic          pop_s;
    logic          pix_inc_s;

    state_e        state_q,      state_d;
    logic [AW:0]   count_q,      count_d;
    logic [AW-1:0] wr_ptr_q,     wr_ptr_d;
    logic [AW-1:0] rd_ptr_q,     rd_ptr_d;
    logic [14:0]   fb_addr_q,    fb_addr_d;
    logic [2:0]    fb_data_q,    fb_data_d;
    logic          fb_wr_en_q,   fb_wr_en_d;
    logic          in_ready_q,   in_ready_d;
    logic          idle_q,       idle_d;
    logic          overflow_q,   overflow_d;
    logic [15:0]   pix_cnt_q,    pix_cnt_d;
    logic [15:0]   clip_cnt_q,   clip_cnt_d;
    logic [15:0]   drop_cnt_q,   drop_cnt_d;

    // Input classification: clip test, linear address and push/drop decision
    always_comb begin
        in_range_s = (32'(pix.vga_x) < 32'(SCR_W)) && (32'(pix.vga_y) < 32'(SCR_H));
        addr_s     = 15'(32'(pix.vga_y) * 32'(SCR_W) + 32'(pix.vga_x));
        clip_s     = pix.vga_plot && !in_range_s;
        push_s     = pix.vga_plot && in_range_s && (count_q < DEPTH_C);
        drop_s     = pix.vga_plot && in_range_s && (count_q == DEPTH_C);
        head_s     = mem_q[rd_ptr_q];
    end

    // Write FSM, FIFO bookkeeping and statistics next-state
    always_comb begin
        state_d   = state_q;
        fb_addr_d = fb_addr_q;
        fb_data_d = fb_data_q;
        pop_s     = 1'b0;
        pix_inc_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (count_q != '0) begin
                    pop_s     = 1'b1;
                    fb_addr_d = head_s[17:3];
                    fb_data_d = head_s[2:0];
                    state_d   = ST_REQ;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (pix.fb_ack) begin
                    pix_inc_s = 1'b1;
                    if (count_q != '0) begin
                        pop_s     = 1'b1;
                        fb_addr_d = head_s[17:3];
                        fb_data_d = head_s[2:0];
                        state_d   = ST_REQ;
                    end else begin
                        state_d   = ST_IDLE;
                    end
                end else begin
                    state_d = ST_REQ;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        count_d  = count_q + (AW + 1)'(push_s) - (AW + 1)'(pop_s);
        wr_ptr_d = push_s ? wr_ptr_q + AW'(1'b1) : wr_ptr_q;
        rd_ptr_d = pop_s  ? rd_ptr_q + AW'(1'b1) : rd_ptr_q;

        // Status outputs are registered copies of what the next state implies
        fb_wr_en_d = (state_d == ST_REQ);
        in_ready_d = (count_d < DEPTH_C);
        idle_d     = (state_d == ST_IDLE) && (count_d == '0);

        if (clr_stats) begin
            overflow_d = 1'b0;
            pix_cnt_d  = 16'd0;
            clip_cnt_d = 16'd0;
            drop_cnt_d = 16'd0;
        end else begin
            overflow_d = overflow_q | drop_s;
            pix_cnt_d  = sat_inc(pix_cnt_q,  pix_inc_s);
            clip_cnt_d = sat_inc(clip_cnt_q, clip_s);
            drop_cnt_d = sat_inc(drop_cnt_q, drop_s);
        end
    end

    // State registers; reset abandons any outstanding write and queued pixels
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fb_addr_q  <= 15'd0;
            fb_data_q  <= 3'd0;
            fb_wr_en_q <= 1'b0;
            in_ready_q <= 1'b1;
            idle_q     <= 1'b1;
            overflow_q <= 1'b0;
            pix_cnt_q  <= 16'd0;
            clip_cnt_q <= 16'd0;
            drop_cnt_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fb_addr_q  <= fb_addr_d;
            fb_data_q  <= fb_data_d;
            fb_wr_en_q <= fb_wr_en_d;
            in_ready_q <= in_ready_d;
            idle_q     <= idle_d;
            overflow_q <= overflow_d;
            pix_cnt_q  <= pix_cnt_d;
            clip_cnt_q <= clip_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // FIFO storage, deliberately not reset
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= {addr_s, pix.vga_colour};
        end
    end

    assign pix.in_ready = in_ready_q;
    assign pix.fb_addr  = fb_addr_q;
    assign pix.fb_data  = fb_data_q;
    assign pix.fb_wr_en = fb_wr_en_q;
    assign idle         = idle_q;
    assign overflow     = overflow_q;
    assign pix_count    = pix_cnt_q;
    assign clip_count   = clip_cnt_q;
    assign drop_count   = drop_cnt_q;

endmodule

// File: doc/vga_plot_sink.md
VGA_PLOT_SINK -- requirements
Module: vga_plot_sink

Interface
REQ-001 Parameter: DEPTH, 8, FIFO entries; power of two, 2..64.
REQ-002 Parameter: SCR_W, 160, screen width in pixels.
REQ-003 Parameter: SCR_H, 120, screen height in pixels.
REQ-004 Port: clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 Port: rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-006 Port: vga_x  input  8  pixel column from a drawing engine.
REQ-007 Port: vga_y  input  7  pixel row.
REQ-008 Port: vga_colour  input  3  pixel colour.
REQ-009 Port: vga_plot  input  1  pixel-valid strobe; one pixel per high cycle; no backpressure honoured by the source.
REQ-010 Port: in_ready  output  1  high when the FIFO can accept a pixel this cycle.
REQ-011 Port: fb_addr  output  15  framebuffer linear address.
REQ-012 Port: fb_data  output  3  framebuffer write colour.
REQ-013 Port: fb_wr_en  output  1  write request; held until acknowledged.
REQ-014 Port: fb_ack  input  1  framebuffer accepts the current write on this edge.
REQ-015 Port: clr_stats  input  1  synchronous clear of all counters and the overflow flag.
REQ-016 Port: idle  output  1  high when the FIFO is empty and no write is outstanding.
REQ-017 Port: overflow  output  1  sticky flag: at least one in-range pixel was dropped.
REQ-018 Port: pix_count, clip_count, drop_count  output  16 each  saturating counters of written, clipped, and dropped pixels.

Function
REQ-019 Clip: a strobe with vga_x >= SCR_W or vga_y >= SCR_H SHALL be discarded, increment clip_count, and never enter the FIFO.
REQ-020 Address: the in-range address SHALL be computed as y*SCR_W + x, e.g. (y<<7)+(y<<5)+x for 160, at 15 bits; the computation SHALL not truncate for SCR_W*SCR_H <= 32768.
REQ-021 Push: an in-range strobe SHALL be written into the FIFO as {addr,colour} on that edge iff the registered count < DEPTH; in_ready = (count < DEPTH).
REQ-022 Full: an in-range strobe while count == DEPTH SHALL be dropped, increment drop_count, and set overflow; this SHALL apply even if a pop occurs on the same edge.
REQ-023 FSM states: IDLE and REQ; fb_wr_en = (state == REQ).
REQ-024 IDLE: if count > 0, the FIFO head SHALL be loaded into the fb_addr/fb_data registers, popped, and the FSM SHALL go to REQ; otherwise it remains IDLE.
REQ-025 REQ without fb_ack: fb_addr, fb_data, and fb_wr_en SHALL hold stable.
REQ-026 REQ with fb_ack: pix_count SHALL increment; if count > 0, the next head SHALL be loaded and popped and the FSM SHALL stay in REQ (one write per cycle with ack tied high); otherwise the FSM SHALL go to IDLE.
REQ-027 Latency: a pixel pushed into an empty FIFO in an idle block SHALL appear on fb_wr_en two edges after its strobe edge.
REQ-028 Empty: no bypass path; a push and a pop on the same edge SHALL leave count unchanged; a pop from an empty FIFO SHALL never occur.
REQ-029 Pointers: read and write pointers SHALL wrap modulo DEPTH; ordering SHALL be strictly FIFO.
REQ-030 Counters: all counters SHALL saturate at 16'hFFFF.
REQ-031 clr_stats: all counters and overflow SHALL be zeroed on the edge; a same-edge increment is lost; FIFO and FSM are unaffected.
REQ-032 idle = (state == IDLE) && (count == 0).
REQ-033 vga_colour SHALL be passed through unmodified; colour 0 SHALL be written like any other colour.

Reset
REQ-034 rst_n low SHALL asynchronously force state=IDLE, count=0, both pointers=0, fb_wr_en=0, fb_addr=0, fb_data=0, all counters=0, overflow=0, so that in_ready=1 and idle=1.
REQ-035 Reset mid-write SHALL abandon the outstanding write and discard all queued pixels; FIFO RAM contents need not be cleared.

Verification
REQ-036 fb_ack=1; single strobe x=5,y=2,c=3 -> fb_wr_en high two edges later with fb_addr=325, fb_data=3, for one cycle; pix_count=1; idle returns high.
REQ-037 Strobes x=160,y=0 and x=0,y=120 -> no fb_wr_en; clip_count=2; pix_count=0.
REQ-038 fb_ack=0; 10 consecutive in-range strobes -> 1 loaded into REQ, 8 queued, 1 dropped; drop_count=1, overflow=1, in_ready=0; after fb_ack is raised, exactly 9 writes in push order.
REQ-039 fb_ack toggling 1,0,1,0 during a 4-pixel burst -> each fb_addr held until acked, no duplicates or skips, pix_count=4.
REQ-040 Assert rst_n low while in REQ with 3 queued -> immediately fb_wr_en=0, idle=1; after release no stale writes.
REQ-041 clr_stats pulse after REQ-038 -> all counters=0, overflow=0; FIFO draining unaffected.
